// File: rtl/instr_encoder.sv
// Packs MIPS instruction descriptors into 32-bit words and writes them to
// sequential instruction-memory addresses over a write/ack handshake.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

  state_t      state;
  logic        last_q;
  logic        legal;
  logic [31:0] word;
  logic [ADDR_W:0] count_next;

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (in_kind)
      3'd0:    word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    word = {6'b000100, in_rs, in_rt, in_imm};
      3'd4:    word = {6'b000010, in_target};
      default: legal = 1'b0;
    endcase
  end

  assign count_next = count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            mem_addr <= BASE;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (legal) begin
              mem_wdata <= word;
              last_q    <= in_last;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            count    <= count_next;
            mem_addr <= mem_addr + 1'b1;
            // last takes priority so a program filling exactly DEPTH words is not an overflow
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (count_next == DEPTH) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: a default-size instance plus a
// 4-word instance for overflow and full-memory cases.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        mem_ack = 1'b0;

  logic        in_ready, mem_we, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_we, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  logic        sel = 1'b0;
  int          ack_delay = 0;
  int          ack_wait = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [7:0]  wr_addr [64];
  logic [31:0] wr_data [64];

  logic        cur_ready, cur_we;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wdata;

  assign cur_ready = sel ? s_in_ready : in_ready;
  assign cur_we    = sel ? s_mem_we : mem_we;
  assign cur_addr  = sel ? {6'b0, s_mem_addr} : mem_addr;
  assign cur_wdata = sel ? s_mem_wdata : mem_wdata;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .done(done), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(mem_ack),
    .count(s_count), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  // imem model: ack after ack_delay cycles of mem_we, driven on the falling edge
  always @(negedge clk) begin
    if (cur_we) begin
      mem_ack  = (ack_wait >= ack_delay);
      ack_wait = ack_wait + 1;
    end else begin
      mem_ack  = 1'b0;
      ack_wait = 0;
    end
  end

  always @(posedge clk) begin
    if (cur_we && mem_ack && wr_cnt < 64) begin
      wr_addr[wr_cnt] = cur_addr;
      wr_data[wr_cnt] = cur_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one descriptor; returns on the falling edge after the accept edge.
  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tg, input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_funct = fn;
    in_imm = imm; in_target = tg; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 50 && !cur_ready; i++) @(negedge clk);
    if (!cur_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", cur_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_write();
    for (int i = 0; i < 50 && cur_we; i++) @(negedge clk);
    if (cur_we) begin
      checks++; errors++;
      $display("FAIL write_timeout mem_we=%0b required=0", cur_we);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({in_ready, mem_we, done, err} !== 4'b0) begin errors++;
      $display("FAIL rst_flags got=%b required=0000", {in_ready, mem_we, done, err}); end
    checks++; if (mem_addr !== 8'h00) begin errors++;
      $display("FAIL rst_addr got=%h required=00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++;
      $display("FAIL rst_wdata got=%h required=0", mem_wdata); end
    checks++; if (count !== 9'd0) begin errors++;
      $display("FAIL rst_count got=%0d required=0", count); end
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({in_ready, mem_we} !== 2'b00) begin errors++;
      $display("FAIL idle_ignores_valid got=%b required=00", {in_ready, mem_we}); end
    in_valid = 1'b0;
  endtask

  task automatic test_r_type();
    int base;
    do_reset();
    base = wr_cnt;
    pulse_start();
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL start_ready got=%b required=1", in_ready); end
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00221820 || mem_addr !== 8'd0) begin errors++;
      $display("FAIL r_word we=%b addr=%h data=%h required 1/00/00221820", mem_we, mem_addr, mem_wdata); end
    wait_write();
    checks++; if (wr_cnt - base !== 1 || wr_data[base] !== 32'h00221820) begin errors++;
      $display("FAIL r_write n=%0d data=%h required 1/00221820", wr_cnt - base, wr_data[base]); end
    checks++; if (count !== 9'd1 || in_ready !== 1'b1) begin errors++;
      $display("FAIL r_count count=%0d ready=%b required 1/1", count, in_ready); end
    pulse_start();
    @(negedge clk);
    checks++; if (count !== 9'd1 || mem_addr !== 8'd1) begin errors++;
      $display("FAIL start_in_accept count=%0d addr=%h required 1/01", count, mem_addr); end
  endtask

  task automatic test_mixed();
    int base;
    logic [31:0] exp [4];
    exp[0] = 32'h8FA80004; exp[1] = 32'hAFA8FFFC; exp[2] = 32'h10220003; exp[3] = 32'h08100000;
    do_reset();
    base = wr_cnt;
    pulse_start();
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0); wait_write();
    send(3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0); wait_write();
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 1'b0); wait_write();
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b1); wait_write();
    checks++; if (wr_cnt - base !== 4) begin errors++;
      $display("FAIL mixed_nwrites got=%0d required=4", wr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== exp[i]) begin errors++;
        $display("FAIL mixed_word%0d addr=%h data=%h required %h/%h", i, wr_addr[base+i],
                 wr_data[base+i], 8'(i), exp[i]); end
    end
    checks++; if ({done, err, in_ready} !== 3'b100 || count !== 9'd4) begin errors++;
      $display("FAIL mixed_done done/err/ready=%b count=%0d required 100/4", {done, err, in_ready}, count); end
  endtask

  task automatic test_ack_delay();
    int base, cyc;
    do_reset();
    base = wr_cnt;
    ack_delay = 3;
    pulse_start();
    send(3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 20 && mem_we; i++) begin
      cyc++;
      checks++; if (mem_addr !== 8'd0 || mem_wdata !== 32'hAFA8FFFC || in_ready !== 1'b0) begin errors++;
        $display("FAIL hold_stable addr=%h data=%h ready=%b required 00/afa8fffc/0", mem_addr, mem_wdata, in_ready); end
      @(negedge clk);
    end
    ack_delay = 0;
    checks++; if (cyc !== 4) begin errors++;
      $display("FAIL hold_cycles got=%0d required=4", cyc); end
    checks++; if (wr_cnt - base !== 1 || count !== 9'd1) begin errors++;
      $display("FAIL hold_one_write n=%0d count=%0d required 1/1", wr_cnt - base, count); end
  endtask

  task automatic test_illegal();
    int base;
    do_reset();
    base = wr_cnt;
    pulse_start();
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0); wait_write();
    send(3'd5, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    checks++; if ({err, mem_we, in_ready, done} !== 4'b1000) begin errors++;
      $display("FAIL illegal_err err/we/ready/done=%b required 1000", {err, mem_we, in_ready, done}); end
    checks++; if (wr_cnt - base !== 1 || count !== 9'd1) begin errors++;
      $display("FAIL illegal_nwrites n=%0d count=%0d required 1/1", wr_cnt - base, count); end
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || err !== 1'b1) begin errors++;
        $display("FAIL err_held ready=%b err=%b required 0/1", in_ready, err); end
    end
    in_valid = 1'b0;
    pulse_start();
    checks++; if ({in_ready, err} !== 2'b10 || count !== 9'd0) begin errors++;
      $display("FAIL err_restart ready/err=%b count=%0d required 10/0", {in_ready, err}, count); end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    sel = 1'b1;
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
      wait_write();
    end
    checks++; if ({s_err, s_done, s_in_ready} !== 3'b100 || s_count !== 3'd4) begin errors++;
      $display("FAIL ovf_err err/done/ready=%b count=%0d required 100/4", {s_err, s_done, s_in_ready}, s_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== (32'h00220020 | (32'(i) << 11))) begin errors++;
        $display("FAIL ovf_word%0d addr=%h data=%h", i, wr_addr[base+i], wr_data[base+i]); end
    end
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wr_cnt - base !== 4 || s_in_ready !== 1'b0) begin errors++;
      $display("FAIL ovf_fifth n=%0d ready=%b required 4/0", wr_cnt - base, s_in_ready); end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20, 16'h0, 26'h0, i == 3);
      wait_write();
    end
    checks++; if ({s_done, s_err} !== 2'b10 || s_count !== 3'd4 || s_mem_addr !== 2'd0) begin errors++;
      $display("FAIL full_done done/err=%b count=%0d addr=%0d required 10/4/0", {s_done, s_err}, s_count, s_mem_addr); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int base;
    do_reset();
    base = wr_cnt;
    pulse_start();
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0); wait_write();
    ack_delay = 5;
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, mem_we, done, err} !== 4'b0 || mem_addr !== 8'd0) begin errors++;
      $display("FAIL async_rst flags=%b addr=%h required 0000/00", {in_ready, mem_we, done, err}, mem_addr); end
    checks++; if (mem_wdata !== 32'h0 || count !== 9'd0) begin errors++;
      $display("FAIL async_rst_data data=%h count=%0d required 0/0", mem_wdata, count); end
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    checks++; if (wr_cnt - base !== 1) begin errors++;
      $display("FAIL rst_drop n=%0d required=1", wr_cnt - base); end
    pulse_start();
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0); wait_write();
    checks++; if (wr_addr[base+1] !== 8'd0 || wr_data[base+1] !== 32'h8FA80004 || count !== 9'd1) begin errors++;
      $display("FAIL rst_restart addr=%h data=%h count=%0d required 00/8fa80004/1",
               wr_addr[base+1], wr_data[base+1], count); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_mixed();
    test_ack_delay();
    test_illegal();
    test_overflow();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
